muldiv32: RTL and testbench

//   Iterative 32-bit multiply/divide unit beside alu32 in the execute stage; consumes the same

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv32_if.sv | 41 ++++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv32.sv | 169 ++++++++++++++++
 tb/tb_muldiv32.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv32 shared types: op codes, FSM states, counter width.
// Optional feature macro: MULDIV_DZ_EN (adds divide-by-zero flag).
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv32_if.sv
// muldiv32 request/result bundle between execute stage and unit.
// MULDIV_DZ_EN adds the dz result flag.
interface muldiv32_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DZ_EN
  logic             dz;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, dz
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
`endif

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring divide on a {upper, lower} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] trial;

  // Multiply: add multiplicand on lsb, shift right.
  // Divide: shift left, keep trial difference if no borrow.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0])
      sum = sum + {1'b0, opnd};
    shl = acc[2*WIDTH-1:WIDTH-1];
    trial = shl - {1'b0, opnd};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (div) begin
      if (!trial[WIDTH])
        acc_next = {trial[WIDTH-1:0],
                    acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shl[WIDTH-1:0],
                    acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv32.sv
// Iterative 32-bit mult/multu/div/divu unit, one bit per clock.
// MULDIV_DZ_EN adds a dz flag in the done cycle of a divide by zero.
module muldiv32
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  muldiv32_if.slave  io
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic               div_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               bz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               in_div;
  logic               in_sgn;
  logic               in_na;
  logic               in_nb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last;
  logic               neg_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_DZ_EN
  logic dz_q;
  assign io.dz = dz_q;
`endif

  assign io.busy = (state_q != IDLE);
  assign io.done = done_q;
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div      (div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_next)
  );

  // Operand decode: magnitudes for signed ops.
  always_comb begin
    in_div = io.op[1];
    in_sgn = !io.op[0];
    in_na  = in_sgn && io.a[WIDTH-1];
    in_nb  = in_sgn && io.b[WIDTH-1];
    abs_a  = in_na ? -io.a : io.a;
    abs_b  = in_nb ? -io.b : io.b;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    last = (cnt_q == CNT_W'(WIDTH-1));
    unique case (state_q)
      IDLE:    if (io.start) state_d = CALC;
      CALC:    if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fix and divide-by-zero result.
  always_comb begin
    neg_q = neg_a_q ^ neg_b_q;
    prod = neg_q ? -acc_q : acc_q;
    rem = acc_q[2*WIDTH-1:WIDTH];
    quo = acc_q[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    unique case (1'b1)
      !div_q: ;
      bz_q: begin
        fix_hi = a_q;
        fix_lo = '1;
      end
      default: begin
        fix_hi = neg_a_q ? -rem : rem;
        fix_lo = neg_q ? -quo : quo;
      end
    endcase
  end

  // Datapath: latch, iterate, publish result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DZ_EN
      dz_q   <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            cnt_q   <= '0;
            a_q     <= io.a;
            div_q   <= in_div;
            neg_a_q <= in_na;
            neg_b_q <= in_nb;
            bz_q    <= in_div && (io.b == '0);
            if (in_div) begin
              acc_q  <= {{WIDTH{1'b0}}, abs_a};
              opnd_q <= abs_b;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, abs_b};
              opnd_q <= abs_a;
            end
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
`ifdef MULDIV_DZ_EN
          dz_q   <= bz_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv32.sv
// Directed self-checking bench for muldiv32.
// Checks dz when built with MULDIV_DZ_EN.
module tb_muldiv32;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   lat;

  muldiv32_if #(.WIDTH(32)) bus ();

  muldiv32 dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait for done, return edge count after E0 (0 = timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic launch(
    input op_t         op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
  endtask

  task automatic run(
    input string       tag,
    input op_t         op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ehi,
    input logic [31:0] elo
  );
    launch(op, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    bus.start = 1'b0;
    bus.op = OP_MULT;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("busy_e0", 64'(bus.busy), 64'd1);
    wait_done(lat);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus.lo), 64'h0000_0001);
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(bus.done), 64'd0);
    chk("hold_hi", 64'(bus.hi), 64'hFFFF_FFFE);

    run("mult", OP_MULT, 32'hFFFF_FFF9, 32'd3,
        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu0", OP_DIVU, 32'd100, 32'd0,
        32'd100, 32'hFFFF_FFFF);
`ifdef MULDIV_DZ_EN
    chk("dz_set", 64'(bus.dz), 64'd1);
`endif
    run("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 32'h8000_0000);
`ifdef MULDIV_DZ_EN
    chk("dz_clr", 64'(bus.dz), 64'd0);
`endif
    run("multu2", OP_MULTU, 32'h1234_5678, 32'h10,
        32'h1, 32'h2345_6780);
    run("divu", OP_DIVU, 32'd100, 32'd7,
        32'd2, 32'd14);
    run("div0s", OP_DIV, 32'hFFFF_FFF9, 32'd0,
        32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Starts while busy are ignored; outputs hold old result.
    launch(OP_DIVU, 32'd1000, 32'd3);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) begin
        chk("nopart_hi", 64'(bus.hi), 64'hFFFF_FFF9);
        chk("busy_mid", 64'(bus.busy), 64'd1);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
      bus.start = (i == 5) || (i == 20);
      bus.op = OP_MULT;
      bus.a = 32'd9;
      bus.b = 32'd9;
    end
    bus.start = 1'b0;
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_hi", 64'(bus.hi), 64'd1);
    chk("ign_lo", 64'(bus.lo), 64'd333);
    @(posedge clk);
    #1;
    chk("ign_idle", 64'(bus.busy), 64'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.a = 32'd6;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.a = 32'd5;
    bus.b = 32'd5;
    wait_done(lat);
    chk("b2b_lat1", 64'(lat), 64'd33);
    chk("b2b_lo1", 64'(bus.lo), 64'd42);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_acc", 64'(bus.busy), 64'd1);
    wait_done(lat);
    chk("b2b_lat2", 64'(lat), 64'd33);
    chk("b2b_lo2", 64'(bus.lo), 64'd25);

    // Reset mid-operation aborts without a done pulse.
    launch(OP_DIVU, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) lat++;
    end
    chk("abort_nodone", 64'(lat), 64'd0);
    run("after", OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
